// File: rtl/movegen_move_stack.sv
// movegen_move_stack: move-word LIFO with one-cycle truncate, sticky flags, optional hwm (MOVE_STACK_HWM_EN)
module movegen_move_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  input  logic             trunc,
  input  logic [CW-1:0]    trunc_level,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    hwm
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] count_nx;
  logic [AW-1:0] wr_idx, top_idx;
  logic ops, we, ovf_set, unf_set;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign top_idx = AW'(count - ONE);
  assign top_data = empty ? '0 : mem[top_idx];
  assign ops = !clear && !trunc;
  assign we = ops && push && (pop || !full);
  assign wr_idx = AW'((pop && !empty) ? count - ONE : count);
  assign ovf_set = ops && push && !pop && full;
  assign unf_set = ops && pop && !push && empty;
  always_comb begin
    count_nx = clear ? '0 :
               trunc ? ((trunc_level < count) ? trunc_level : count) :
               (push && (pop ? empty : !full)) ? count + ONE :
               (pop && !push && !empty) ? count - ONE : count;
  end
  always_ff @(posedge clk) begin
    if (we && rst_n) mem[wr_idx] <= in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nx;
      overflow <= !clear && (overflow || ovf_set);
      underflow <= !clear && (underflow || unf_set);
    end
  end
`ifdef MOVE_STACK_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm <= '0;
    else hwm <= clear ? '0 : ((count_nx > hwm) ? count_nx : hwm);
  end
`else
  assign hwm = '0;
`endif
endmodule

// File: tb/tb_movegen_move_stack.sv
// tb_movegen_move_stack: directed checks on a 64-deep and a 4-deep stack driven in parallel
module tb_movegen_move_stack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, push = 1'b0, pop = 1'b0, trunc = 1'b0;
  logic [9:0] in_data = '0;
  logic [6:0] tl = '0;
  logic [9:0] a_top, b_top;
  logic [6:0] a_cnt, a_hwm;
  logic [2:0] b_cnt, b_hwm;
  logic a_empty, a_full, a_ovf, a_unf, b_empty, b_full, b_ovf, b_unf;
  int checks = 0;
  int failures = 0;
`ifdef MOVE_STACK_HWM_EN
  localparam logic [6:0] HWM_A = 7'd7;
  localparam logic [2:0] HWM_B = 3'd4;
`else
  localparam logic [6:0] HWM_A = 7'd0;
  localparam logic [2:0] HWM_B = 3'd0;
`endif

  always #5 clk = ~clk;

  movegen_move_stack u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .in_data(in_data), .pop(pop),
    .trunc(trunc), .trunc_level(tl), .top_data(a_top), .count(a_cnt), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf), .hwm(a_hwm)
  );

  movegen_move_stack #(.DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .in_data(in_data), .pop(pop),
    .trunc(trunc), .trunc_level(tl[2:0]), .top_data(b_top), .count(b_cnt), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf), .hwm(b_hwm)
  );

  task automatic op(input logic p, input logic po, input logic tr, input logic cl,
                    input logic [9:0] d, input logic [6:0] l);
    push = p; pop = po; trunc = tr; clear = cl; in_data = d; tl = l;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; trunc = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (a_cnt !== 7'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", a_cnt); end
    checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin failures++; $display("FAIL rst_empty_full got=%b%b exp=10", a_empty, a_full); end
    checks++; if (a_top !== 10'h0) begin failures++; $display("FAIL rst_top got=%h exp=000", a_top); end
    checks++; if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {a_ovf, a_unf, b_ovf, b_unf}); end
    checks++; if (a_hwm !== 7'd0) begin failures++; $display("FAIL rst_hwm got=%0d exp=0", a_hwm); end
  endtask

  task automatic test_push_pop;
    op(1, 0, 0, 0, 10'h001, 0);
    op(1, 0, 0, 0, 10'h002, 0);
    op(1, 0, 0, 0, 10'h003, 0);
    checks++; if (a_cnt !== 7'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", a_cnt); end
    checks++; if (a_top !== 10'h003) begin failures++; $display("FAIL pp_top got=%h exp=003", a_top); end
    checks++; if (a_empty !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", a_empty); end
    op(0, 1, 0, 0, 10'h0, 0);
    op(0, 1, 0, 0, 10'h0, 0);
    checks++; if (a_top !== 10'h001 || a_cnt !== 7'd1) begin failures++; $display("FAIL pp_pop got=%h/%0d exp=001/1", a_top, a_cnt); end
    checks++; if (a_unf !== 1'b0) begin failures++; $display("FAIL pp_unf got=%b exp=0", a_unf); end
  endtask

  task automatic test_overflow;
    op(0, 0, 0, 1, 10'h0, 0);
    for (int i = 0; i < 5; i++) op(1, 0, 0, 0, 10'(16 + i), 0);
    checks++; if (b_full !== 1'b1 || b_cnt !== 3'd4) begin failures++; $display("FAIL ovf_full got=%b/%0d exp=1/4", b_full, b_cnt); end
    checks++; if (b_top !== 10'h013) begin failures++; $display("FAIL ovf_top got=%h exp=013", b_top); end
    checks++; if (b_ovf !== 1'b1 || a_ovf !== 1'b0) begin failures++; $display("FAIL ovf_flag got=%b%b exp=10", b_ovf, a_ovf); end
    op(1, 1, 0, 0, 10'h3FF, 0);
    checks++; if (b_top !== 10'h3FF || b_cnt !== 3'd4) begin failures++; $display("FAIL ovf_replace got=%h/%0d exp=3ff/4", b_top, b_cnt); end
    checks++; if (a_top !== 10'h3FF || a_cnt !== 7'd5) begin failures++; $display("FAIL replace_a got=%h/%0d exp=3ff/5", a_top, a_cnt); end
  endtask

  task automatic test_underflow;
    op(0, 0, 0, 1, 10'h0, 0);
    checks++; if (b_ovf !== 1'b0 || b_cnt !== 3'd0) begin failures++; $display("FAIL clr_b got=%b/%0d exp=0/0", b_ovf, b_cnt); end
    op(0, 1, 0, 0, 10'h0, 0);
    checks++; if (a_cnt !== 7'd0 || a_top !== 10'h0) begin failures++; $display("FAIL unf_state got=%0d/%h exp=0/000", a_cnt, a_top); end
    checks++; if (a_unf !== 1'b1 || b_unf !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b%b exp=11", a_unf, b_unf); end
    op(1, 1, 0, 0, 10'h055, 0);
    checks++; if (a_cnt !== 7'd1 || a_top !== 10'h055) begin failures++; $display("FAIL pp_empty_a got=%0d/%h exp=1/055", a_cnt, a_top); end
    checks++; if (b_cnt !== 3'd1 || b_top !== 10'h055 || b_unf !== 1'b1) begin failures++; $display("FAIL pp_empty_b got=%0d/%h/%b exp=1/055/1", b_cnt, b_top, b_unf); end
  endtask

  task automatic test_trunc;
    op(0, 0, 0, 1, 10'h0, 0);
    for (int i = 1; i <= 6; i++) op(1, 0, 0, 0, 10'(32 + i), 0);
    checks++; if (a_cnt !== 7'd6) begin failures++; $display("FAIL tr_fill got=%0d exp=6", a_cnt); end
    op(1, 0, 1, 0, 10'h3AA, 7'd2);
    checks++; if (a_cnt !== 7'd2 || a_top !== 10'h022) begin failures++; $display("FAIL tr_cut got=%0d/%h exp=2/022", a_cnt, a_top); end
    checks++; if (b_cnt !== 3'd2 || b_top !== 10'h022) begin failures++; $display("FAIL tr_cut_b got=%0d/%h exp=2/022", b_cnt, b_top); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL tr_noflag got=%b exp=0", a_ovf); end
    op(0, 1, 1, 0, 10'h0, 7'd5);
    checks++; if (a_cnt !== 7'd2 || b_cnt !== 3'd2) begin failures++; $display("FAIL tr_above got=%0d/%0d exp=2/2", a_cnt, b_cnt); end
  endtask

  task automatic test_hwm;
    op(0, 0, 0, 1, 10'h0, 0);
    for (int i = 1; i <= 7; i++) op(1, 0, 0, 0, 10'(48 + i), 0);
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0, 10'h0, 0);
    op(1, 0, 0, 0, 10'h040, 0);
    checks++; if (a_cnt !== 7'd4 || a_top !== 10'h040) begin failures++; $display("FAIL hwm_state got=%0d/%h exp=4/040", a_cnt, a_top); end
    checks++; if (a_hwm !== HWM_A) begin failures++; $display("FAIL hwm_a got=%0d exp=%0d", a_hwm, HWM_A); end
    checks++; if (b_hwm !== HWM_B || b_cnt !== 3'd1) begin failures++; $display("FAIL hwm_b got=%0d/%0d exp=%0d/1", b_hwm, b_cnt, HWM_B); end
    op(0, 0, 0, 1, 10'h0, 0);
    checks++; if (a_cnt !== 7'd0 || a_hwm !== 7'd0 || b_ovf !== 1'b0) begin failures++; $display("FAIL hwm_clear got=%0d/%0d/%b exp=0/0/0", a_cnt, a_hwm, b_ovf); end
  endtask

  task automatic test_async_reset;
    op(0, 1, 0, 0, 10'h0, 0);
    for (int i = 1; i <= 5; i++) op(1, 0, 0, 0, 10'(80 + i), 0);
    op(0, 1, 0, 0, 10'h0, 0);
    op(0, 1, 0, 0, 10'h0, 0);
    checks++; if (a_cnt !== 7'd3 || a_top !== 10'h053 || b_ovf !== 1'b1 || a_unf !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%h/%b/%b exp=3/053/1/1", a_cnt, a_top, b_ovf, a_unf); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_cnt !== 7'd0 || a_top !== 10'h0 || a_empty !== 1'b1) begin failures++; $display("FAIL ar_state got=%0d/%h/%b exp=0/000/1", a_cnt, a_top, a_empty); end
    checks++; if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0 || b_cnt !== 3'd0) begin failures++; $display("FAIL ar_flags got=%b/%0d exp=0000/0", {a_ovf, a_unf, b_ovf, b_unf}, b_cnt); end
    @(negedge clk) rst_n = 1'b1;
    op(0, 0, 0, 0, 10'h0, 0);
    checks++; if (a_cnt !== 7'd0 || a_hwm !== 7'd0) begin failures++; $display("FAIL ar_post got=%0d/%0d exp=0/0", a_cnt, a_hwm); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_trunc();
    test_hwm();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/movegen_move_stack.md
# movegen_move_stack

Parametrised LIFO of move words for the move generator, the successor of the single-entry piece stack cell. Generated moves are pushed as they are produced and popped by the search controller. Ply boundaries are unwound in one cycle by truncating to a saved depth. Sticky overflow and underflow flags, plus an optional high-water mark, make stack sizing observable in simulation and on hardware.

## Interface
- WIDTH, 10, bits per stored move word
- DEPTH, 64, number of entries; must be ≥ 2
- CW, $clog2(DEPTH+1), width of count and level ports (derived; not overridden)

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous empty-the-stack, clears error flags
- push  in  1  push in_data this cycle
- in_data  in  WIDTH  word to push
- pop  in  1  discard top entry this cycle
- trunc  in  1  unwind stack to trunc_level
- trunc_level  in  CW  target depth for trunc
- top_data  out  WIDTH  current top entry; 0 when empty
- count  out  CW  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push dropped because full
- underflow  out  1  sticky: pop with nothing to pop
- hwm  out  CW  maximum count reached since reset/clear (see Configuration)

## Operation
- Storage is a DEPTH×WIDTH register array plus a CW-bit pointer (count). Entry i occupies slot i. Top is slot count-1.
- Per-cycle priority: rst_n low > clear > trunc > push/pop.
- clear: count←0, overflow←0, underflow←0, hwm←0. Array contents are not erased.
- trunc: if trunc_level < count, then count←trunc_level, else no change. Push and pop in the same cycle are ignored and flag nothing.
- push only: if not full, slot[count]←in_data and count+1. If full, no change and overflow←1.
- pop only: if not empty, count-1. If empty, no change and underflow←1.
- push+pop:
  - Not empty: slot[count-1]←in_data (top replaced), count unchanged, no flags. This also holds when full.
  - Empty: behaves as push only, no underflow.
- top_data = slot[count-1] when count>0, else 0. Driven from registers only, with no combinational path from inputs.
- empty and full are decoded from the count register.
- Flags stay set until clear or reset.

## Timing
- Reset (async assert, sync-released by the system) values:
  - count=0, empty=1, full=0
  - top_data=0
  - overflow=0, underflow=0, hwm=0
  - Array contents are don't-care.
- Push latency: 1 cycle. Pushed word is on top_data and count updated on the cycle after the push edge.
- Pop latency: 1 cycle. Previous entry appears on top_data the next cycle.
- Back-to-back push or pop every cycle is supported at full rate. There is no ready/backpressure; callers check full and empty.
- Reset asserted mid-operation aborts in-flight updates immediately. Outputs reach their reset values asynchronously.
- Truncation completes in one cycle regardless of the distance unwound.

## Configuration
- MOVE_STACK_HWM_EN defined:
  - hwm register updated every cycle to max(hwm, next count).
  - Cleared by clear and by reset.
- Not defined:
  - hwm tied to 0.
  - No comparator or register is synthesised.
  - The port remains present.

## Test plan
- Reset then push 0x001,0x002,0x003 on consecutive cycles → count=3, top_data=0x003, empty=0. Pop twice → top_data=0x001, count=1.
- DEPTH=4: push 5 words 0x10..0x14 → full=1, count=4, top_data=0x13, overflow=1. Then push+pop 0x3FF → top_data=0x3FF, count=4.
- Pop on empty → count=0, top_data=0, underflow=1. Push+pop 0x055 on empty → count=1, top_data=0x055.
- Push 6 words, trunc with trunc_level=2 plus push asserted → count=2, top_data=2nd word. Then trunc with trunc_level=5 → count stays 2.
- With MOVE_STACK_HWM_EN: push 7, pop 4, push 1 → hwm=7. Then clear → count=0, hwm=0, overflow=0. Without the macro hwm=0 throughout.
- Assert rst_n low between clock edges with count=3 and flags set → count=0, top_data=0, all flags 0 before the next edge.
